// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encodings and the
// default bus widths used by the processor and RAM.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 8;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/mem_arbiter_rr_select.sv
// Combinational round-robin selector: finds the first requesting port after
// the last grant, wrapping modulo NPORTS.
module rr_select
  import mem_arbiter_pkg::*;
#(
  parameter int NPORTS = 2
) (
  input  logic [NPORTS-1:0]         req,
  input  logic [$clog2(NPORTS)-1:0] last_grant,
  output logic                      any_req,
  output logic [$clog2(NPORTS)-1:0] next_grant
);

  localparam int IDX_W = $clog2(NPORTS);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  // Scan last+1 .. last+NPORTS; the last candidate is the previous grant itself.
  always_comb begin
    any_req    = |req;
    next_grant = last_grant;
    cand       = 0;
    cand_idx   = '0;
    found      = 1'b0;
    for (int k = 1; k <= NPORTS; k++) begin
      cand     = (int'(last_grant) + k) % NPORTS;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        next_grant = cand_idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-port RAM arbiter: round-robin grant, fixed-length RAM access with
// configurable wait states, and a one-cycle ack back to the granted port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NPORTS      = 2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NPORTS-1:0]         req,
  input  logic [NPORTS-1:0]         we,
  input  logic [NPORTS*ADDR_W-1:0]  addr_in,
  input  logic [NPORTS*DATA_W-1:0]  wdata_in,
  output logic [NPORTS-1:0]         ack,
  output logic [DATA_W-1:0]         rdata_out,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata,
  output logic                      ram_re,
  output logic                      ram_we,
  output logic                      busy,
  output logic [$clog2(NPORTS)-1:0] grant_id
);

  localparam int IDX_W = $clog2(NPORTS);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ram_re_q, ram_re_d;
  logic              ram_we_q, ram_we_d;
  logic [NPORTS-1:0] ack_q, ack_d;
  logic              busy_q, busy_d;

  logic              any_req;
  logic [IDX_W-1:0]  next_grant;
  logic [ADDR_W-1:0] addr_arr  [NPORTS];
  logic [DATA_W-1:0] wdata_arr [NPORTS];

  rr_select #(.NPORTS(NPORTS)) u_rr_select (
    .req        (req),
    .last_grant (grant_q),
    .any_req    (any_req),
    .next_grant (next_grant)
  );

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      addr_arr[i]  = addr_in[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = wdata_in[i*DATA_W +: DATA_W];
    end
  end

  // Strobes and ack are computed one cycle ahead so they leave the flops clean.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    ram_re_d = 1'b0;
    ram_we_d = 1'b0;
    ack_d    = '0;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (any_req) begin
          grant_d  = next_grant;
          addr_d   = addr_arr[next_grant];
          wdata_d  = wdata_arr[next_grant];
          we_d     = we[next_grant];
          cnt_d    = CNT_W'(WAIT_CYCLES);
          state_d  = ACCESS;
          busy_d   = 1'b1;
          ram_re_d = !we[next_grant];
          ram_we_d = we[next_grant] && (WAIT_CYCLES == 0);
        end
      end
      ACCESS: begin
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          state_d        = DONE;
          ack_d[grant_q] = 1'b1;
          if (!we_q) begin
            rdata_d = ram_rdata;
          end
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          ram_re_d = !we_q;
          ram_we_d = we_q && (cnt_q == CNT_W'(1));
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      grant_q  <= IDX_W'(NPORTS - 1);
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      ram_re_q <= 1'b0;
      ram_we_q <= 1'b0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      ram_re_q <= ram_re_d;
      ram_we_q <= ram_we_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign rdata_out = rdata_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_re    = ram_re_q;
  assign ram_we    = ram_we_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a WAIT=1 instance with a registered RAM
// model, a WAIT=0 instance with fixed-content RAM, and a WAIT=3 instance.
module tb_mem_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;
  localparam int NP = 2;

  typedef struct {
    int         port;
    bit         rd;
    logic [7:0] data;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   last_grant;

  logic clk, rst_n;

  logic [NP-1:0]    req, we, ack;
  logic [NP*AW-1:0] addr_in;
  logic [NP*DW-1:0] wdata_in;
  logic [DW-1:0]    rdata_out, ram_wdata, ram_rdata;
  logic [AW-1:0]    ram_addr;
  logic             ram_re, ram_we, busy;
  logic [0:0]       grant_id;

  logic [NP-1:0]    req0, we0, ack0;
  logic [NP*AW-1:0] addr_in0;
  logic [NP*DW-1:0] wdata_in0;
  logic [DW-1:0]    rdata_out0, ram_wdata0, ram_rdata0;
  logic [AW-1:0]    ram_addr0;
  logic             ram_re0, ram_we0, busy0;
  logic [0:0]       grant_id0;

  logic [NP-1:0]    req3, we3, ack3;
  logic [NP*AW-1:0] addr_in3;
  logic [NP*DW-1:0] wdata_in3;
  logic [DW-1:0]    rdata_out3, ram_wdata3, ram_rdata3;
  logic [AW-1:0]    ram_addr3;
  logic             ram_re3, ram_we3, busy3;
  logic [0:0]       grant_id3;

  logic             pre_en;
  logic [AW-1:0]    pre_addr;
  logic [DW-1:0]    pre_data;
  logic [DW-1:0]    mem [0:(1<<AW)-1];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NPORTS(NP), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr_in(addr_in), .wdata_in(wdata_in),
    .ack(ack), .rdata_out(rdata_out), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_re(ram_re), .ram_we(ram_we), .busy(busy), .grant_id(grant_id));

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NPORTS(NP), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .addr_in(addr_in0), .wdata_in(wdata_in0),
    .ack(ack0), .rdata_out(rdata_out0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0),
    .ram_rdata(ram_rdata0), .ram_re(ram_re0), .ram_we(ram_we0), .busy(busy0), .grant_id(grant_id0));

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NPORTS(NP), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .we(we3), .addr_in(addr_in3), .wdata_in(wdata_in3),
    .ack(ack3), .rdata_out(rdata_out3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
    .ram_rdata(ram_rdata3), .ram_re(ram_re3), .ram_we(ram_we3), .busy(busy3), .grant_id(grant_id3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM behind the WAIT=1 instance, with a backdoor preload port.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  assign ram_rdata0 = ram_addr0[7:0] ^ 8'h5A;
  assign ram_rdata3 = 8'h00;

  function automatic int rr_next(input logic [1:0] r, input int last);
    for (int k = 1; k <= NP; k++) begin
      int p = (last + k) % NP;
      if (r[p]) return p;
    end
    return last;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Drives one request on the WAIT=1 instance and observes it until ack.
  task automatic do_access(input int port, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input bit drop_early,
                           output int lat, output int re_cnt, output logic [7:0] re_mask,
                           output int we_cnt, output logic [AW-1:0] we_addr,
                           output logic [DW-1:0] we_data, output logic [1:0] ack_seen,
                           output logic [0:0] grant_seen);
    lat = 0; re_cnt = 0; re_mask = '0; we_cnt = 0; we_addr = '0; we_data = '0;
    ack_seen = '0; grant_seen = '0;
    req = '0; req[port] = 1'b1; we[port] = wr;
    addr_in[port*AW +: AW] = a; wdata_in[port*DW +: DW] = d;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (drop_early && c == 1) req[port] = 1'b0;
      if (ram_re) begin re_cnt++; if (c < 8) re_mask[c] = 1'b1; end
      if (ram_we) begin we_cnt++; we_addr = ram_addr; we_data = ram_wdata; end
      if (ack != '0) begin
        lat = c; ack_seen = ack; grant_seen = grant_id; req[port] = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    req = '0; we = '0; addr_in = '0; wdata_in = '0;
    req0 = '0; we0 = '0; addr_in0 = '0; wdata_in0 = '0;
    req3 = '0; we3 = '0; addr_in3 = '0; wdata_in3 = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (ack !== 2'b00) begin bad++; $display("[TB] FAIL reset_ack got=%b exp=00", ack); end
    total++; if (ram_re !== 1'b0 || ram_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_strobes got re=%b we=%b exp=0", ram_re, ram_we); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    total++; if (rdata_out !== 8'h00) begin bad++; $display("[TB] FAIL reset_rdata got=%h exp=00", rdata_out); end
    total++; if (ram_addr !== 15'h0 || ram_wdata !== 8'h0) begin bad++; $display("[TB] FAIL reset_ram_bus got=%h/%h exp=0/0", ram_addr, ram_wdata); end
    total++; if (grant_id !== 1'b1) begin bad++; $display("[TB] FAIL reset_grant got=%0d exp=1", grant_id); end
    total++; if (busy0 !== 1'b0 || grant_id0 !== 1'b1) begin bad++; $display("[TB] FAIL reset_dut0 got busy=%b grant=%0d exp=0/1", busy0, grant_id0); end
    rst_n = 1'b1;
    last_grant = NP - 1;
  endtask

  task automatic test_single_read();
    int lat, re_cnt, we_cnt; logic [7:0] re_mask; logic [AW-1:0] wa; logic [DW-1:0] wd;
    logic [1:0] ackv; logic [0:0] g; exp_t e;
    preload(15'h0010, 8'hA5);
    sbq.push_back('{port: rr_next(2'b01, last_grant), rd: 1'b1, data: 8'hA5});
    do_access(0, 1'b0, 15'h0010, 8'h00, 1'b0, lat, re_cnt, re_mask, we_cnt, wa, wd, ackv, g);
    e = sbq.pop_front();
    total++; if (lat !== 3) begin bad++; $display("[TB] FAIL read_latency got=%0d exp=3", lat); end
    total++; if (ackv !== (2'b01 << e.port) || g !== 1'(e.port)) begin bad++; $display("[TB] FAIL read_ack got=%b/%0d exp=%b/%0d", ackv, g, 2'b01 << e.port, e.port); end
    total++; if (rdata_out !== e.data) begin bad++; $display("[TB] FAIL read_data got=%h exp=%h", rdata_out, e.data); end
    total++; if (re_mask !== 8'b0000_0110 || we_cnt != 0) begin bad++; $display("[TB] FAIL read_strobes got re=%b we=%0d exp=00000110/0", re_mask, we_cnt); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL read_busy_after got=%b exp=0", busy); end
    last_grant = e.port;
  endtask

  task automatic test_write_read();
    int lat, re_cnt, we_cnt; logic [7:0] re_mask; logic [AW-1:0] wa; logic [DW-1:0] wd;
    logic [1:0] ackv; logic [0:0] g; exp_t e;
    sbq.push_back('{port: 1, rd: 1'b0, data: 8'hA5});
    do_access(1, 1'b1, 15'h7FFF, 8'h3C, 1'b0, lat, re_cnt, re_mask, we_cnt, wa, wd, ackv, g);
    e = sbq.pop_front();
    total++; if (lat !== 3 || ackv !== 2'b10) begin bad++; $display("[TB] FAIL write_ack got lat=%0d ack=%b exp=3/10", lat, ackv); end
    total++; if (we_cnt != 1 || wa !== 15'h7FFF || wd !== 8'h3C) begin bad++; $display("[TB] FAIL write_pulse got n=%0d a=%h d=%h exp=1/7fff/3c", we_cnt, wa, wd); end
    total++; if (re_cnt != 0 || rdata_out !== e.data) begin bad++; $display("[TB] FAIL write_no_read got re=%0d rdata=%h exp=0/%h", re_cnt, rdata_out, e.data); end
    @(negedge clk);
    sbq.push_back('{port: 1, rd: 1'b1, data: 8'h3C});
    do_access(1, 1'b0, 15'h7FFF, 8'h00, 1'b0, lat, re_cnt, re_mask, we_cnt, wa, wd, ackv, g);
    e = sbq.pop_front();
    total++; if (ackv !== 2'b10 || rdata_out !== e.data) begin bad++; $display("[TB] FAIL readback_top got ack=%b data=%h exp=10/%h", ackv, rdata_out, e.data); end
    @(negedge clk);
    sbq.push_back('{port: 0, rd: 1'b0, data: 8'h3C});
    do_access(0, 1'b1, 15'h0000, 8'h5E, 1'b0, lat, re_cnt, re_mask, we_cnt, wa, wd, ackv, g);
    e = sbq.pop_front();
    total++; if (we_cnt != 1 || wa !== 15'h0000 || ackv !== 2'b01 || rdata_out !== e.data) begin bad++; $display("[TB] FAIL write_zero got n=%0d a=%h ack=%b rdata=%h exp=1/0000/01/%h", we_cnt, wa, ackv, rdata_out, e.data); end
    @(negedge clk);
    sbq.push_back('{port: 0, rd: 1'b1, data: 8'h5E});
    do_access(0, 1'b0, 15'h0000, 8'h00, 1'b0, lat, re_cnt, re_mask, we_cnt, wa, wd, ackv, g);
    e = sbq.pop_front();
    total++; if (rdata_out !== e.data) begin bad++; $display("[TB] FAIL readback_zero got=%h exp=%h", rdata_out, e.data); end
    @(negedge clk);
    last_grant = 0;
  endtask

  task automatic test_contention();
    int lp, nack, prev; exp_t e;
    lp = last_grant;
    for (int k = 0; k < 4; k++) begin
      lp = rr_next(2'b11, lp);
      sbq.push_back('{port: lp, rd: 1'b1, data: (lp == 0) ? 8'hA5 : 8'h3C});
    end
    we = 2'b00; addr_in[0 +: AW] = 15'h0010; addr_in[AW +: AW] = 15'h7FFF; req = 2'b11;
    nack = 0; prev = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        e = sbq.pop_front();
        total++; if (ack !== (2'b01 << e.port) || grant_id !== 1'(e.port)) begin bad++; $display("[TB] FAIL contend_grant%0d got ack=%b g=%0d exp port %0d", nack, ack, grant_id, e.port); end
        total++; if (rdata_out !== e.data) begin bad++; $display("[TB] FAIL contend_data%0d got=%h exp=%h", nack, rdata_out, e.data); end
        total++; if ((nack == 0 && c != 3) || (nack > 0 && c - prev != 4)) begin bad++; $display("[TB] FAIL contend_spacing%0d got cycle=%0d prev=%0d exp spacing 4", nack, c, prev); end
        prev = c; nack++; last_grant = e.port;
        if (nack == 4) begin req = 2'b00; break; end
      end
    end
    total++; if (nack != 4) begin bad++; $display("[TB] FAIL contend_count got=%0d exp=4", nack); req = 2'b00; sbq.delete(); end
    @(negedge clk);
  endtask

  task automatic test_dropped();
    int lat, re_cnt, we_cnt, extra; logic [7:0] re_mask; logic [AW-1:0] wa; logic [DW-1:0] wd;
    logic [1:0] ackv; logic [0:0] g; exp_t e;
    sbq.push_back('{port: 0, rd: 1'b1, data: 8'hA5});
    do_access(0, 1'b0, 15'h0010, 8'h00, 1'b1, lat, re_cnt, re_mask, we_cnt, wa, wd, ackv, g);
    e = sbq.pop_front();
    total++; if (lat !== 3 || ackv !== 2'b01 || rdata_out !== e.data) begin bad++; $display("[TB] FAIL drop_ack got lat=%0d ack=%b data=%h exp=3/01/%h", lat, ackv, rdata_out, e.data); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL drop_busy got=%b exp=0", busy); end
    extra = 0;
    repeat (5) begin @(negedge clk); if (ack != '0 || busy) extra++; end
    total++; if (extra != 0) begin bad++; $display("[TB] FAIL drop_extra got=%0d exp=0", extra); end
    last_grant = 0;
  endtask

  task automatic test_wait0();
    int lat, re_cnt; logic [1:0] ackv; exp_t e;
    sbq.push_back('{port: 0, rd: 1'b1, data: 8'h23 ^ 8'h5A});
    we0 = 2'b00; addr_in0[0 +: AW] = 15'h0123; req0 = 2'b01;
    lat = 0; re_cnt = 0; ackv = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ram_re0) re_cnt++;
      if (ack0 != '0) begin lat = c; ackv = ack0; req0 = 2'b00; break; end
    end
    req0 = 2'b00;
    e = sbq.pop_front();
    total++; if (lat !== 2 || ackv !== 2'b01) begin bad++; $display("[TB] FAIL wait0_ack got lat=%0d ack=%b exp=2/01", lat, ackv); end
    total++; if (re_cnt != 1) begin bad++; $display("[TB] FAIL wait0_re got=%0d exp=1", re_cnt); end
    total++; if (rdata_out0 !== e.data) begin bad++; $display("[TB] FAIL wait0_data got=%h exp=%h", rdata_out0, e.data); end
    @(negedge clk);
    total++; if (busy0 !== 1'b0) begin bad++; $display("[TB] FAIL wait0_busy got=%b exp=0", busy0); end
  endtask

  task automatic test_reset_mid_write();
    int wcnt, acnt;
    we3 = 2'b10; addr_in3[AW +: AW] = 15'h0100; wdata_in3[DW +: DW] = 8'h3C; req3 = 2'b10;
    @(negedge clk);
    total++; if (busy3 !== 1'b1 || ram_addr3 !== 15'h0100) begin bad++; $display("[TB] FAIL abort_setup got busy=%b a=%h exp=1/0100", busy3, ram_addr3); end
    rst_n = 1'b0; req3 = 2'b00;
    #1;
    total++; if (busy3 !== 1'b0 || ram_addr3 !== 15'h0 || ram_wdata3 !== 8'h0) begin bad++; $display("[TB] FAIL abort_outputs got busy=%b a=%h d=%h exp=0/0/0", busy3, ram_addr3, ram_wdata3); end
    total++; if (grant_id3 !== 1'b1 || ram_re3 !== 1'b0 || ram_we3 !== 1'b0 || ack3 !== 2'b00) begin bad++; $display("[TB] FAIL abort_strobes got g=%0d re=%b we=%b ack=%b exp=1/0/0/00", grant_id3, ram_re3, ram_we3, ack3); end
    wcnt = 0; acnt = 0;
    repeat (2) begin @(negedge clk); if (ram_we3) wcnt++; if (ack3 != '0) acnt++; end
    rst_n = 1'b1;
    repeat (8) begin @(negedge clk); if (ram_we3) wcnt++; if (ack3 != '0) acnt++; end
    total++; if (wcnt != 0 || acnt != 0) begin bad++; $display("[TB] FAIL abort_silent got we=%0d ack=%0d exp=0/0", wcnt, acnt); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_dropped();
    test_wait0();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, address width in bits.
REQ-002 Parameter DATA_W, default 8, data width in bits.
REQ-003 Parameter NPORTS, default 2, requester channel count, range 2..8.
REQ-004 Parameter WAIT_CYCLES, default 1, extra RAM access cycles, range 0..15.
REQ-005 Clock and reset SHALL be exactly as decided: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
REQ-006 clk  input  1  rising-edge system clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 req  input  NPORTS  per-port access request.
REQ-009 we  input  NPORTS  per-port write select (1 write, 0 read).
REQ-010 addr_in  input  NPORTS*ADDR_W  packed per-port addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-011 wdata_in  input  NPORTS*DATA_W  packed per-port write data, same packing.
REQ-012 ack  output  NPORTS  one-cycle completion pulse to the granted port.
REQ-013 rdata_out  output  DATA_W  read data; valid in the ack cycle, held until the next read completes.
REQ-014 ram_addr  output  ADDR_W  RAM address.
REQ-015 ram_wdata  output  DATA_W  RAM write data.
REQ-016 ram_rdata  input  DATA_W  RAM registered read data.
REQ-017 ram_re  output  1  RAM read strobe.
REQ-018 ram_we  output  1  RAM write strobe.
REQ-019 busy  output  1  high in any state other than IDLE.
REQ-020 grant_id  output  clog2(NPORTS)  index of the currently or most recently granted port.

Function
REQ-021 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-022 In IDLE with any req bit high, select one port round-robin, starting at (last grant + 1) mod NPORTS.
REQ-023 In the same IDLE cycle, latch that port's addr, wdata and we, load wait counter = WAIT_CYCLES, and go to ACCESS.
REQ-024 ACCESS SHALL last WAIT_CYCLES+1 cycles, driving the latched ram_addr and ram_wdata throughout.
REQ-025 For reads, ram_re SHALL be high for all ACCESS cycles; ram_rdata is captured into rdata_out at the final ACCESS edge.
REQ-026 For writes, ram_we SHALL be high only on the final ACCESS cycle; ram_re stays low; rdata_out is unchanged.
REQ-027 DONE SHALL pulse ack[grant_id] for exactly one cycle, then return to IDLE.
REQ-028 Latency: req sampled in IDLE cycle t gives ack in cycle t+WAIT_CYCLES+2.
REQ-029 req SHALL be ignored outside IDLE; other ports' requests wait.
REQ-030 If req is dropped mid-access, the access still completes and ack is still pulsed.
REQ-031 A port holding req through ack SHALL be eligible again in the next IDLE cycle, subject to round-robin order.
REQ-032 Under continuous multi-port requests, each requesting port SHALL be granted within NPORTS grants.
REQ-033 Outside ACCESS, ram_re and ram_we SHALL be 0; ram_addr and ram_wdata hold their last values.
REQ-034 Addresses pass unmodified: 0 and 2^ADDR_W-1 are legal, with no wrap or offset.

Reset
REQ-035 On rst_n low: state IDLE, ack 0, ram_re 0, ram_we 0, busy 0, rdata_out 0, ram_addr 0, ram_wdata 0, grant_id NPORTS-1 (so port 0 has first priority).
REQ-036 Reset asserted mid-ACCESS SHALL abort immediately: no ram_we pulse and no ack for the aborted access.
REQ-037 The first IDLE evaluation SHALL occur at the first rising clk after rst_n deasserts.

Structure
REQ-038 A shared package/header SHALL hold the state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and the default ADDR_W/DATA_W values used by the processor and RAM.
REQ-039 The round-robin selector SHALL be one sub-module, rr_select (inputs req and last grant; outputs any_req and next grant index), purely combinational.
REQ-040 The FSM, wait counter and datapath registers SHALL reside in mem_arbiter.

Verification
REQ-041 Single read: WAIT=1, port0 reads 0x0010 with RAM[0x0010]=0xA5, req at cycle 0 -> ram_re high cycles 1-2, ack[0] at cycle 3, rdata_out=0xA5.
REQ-042 Write then read: port1 writes 0x3C to 0x7FFF -> exactly one ram_we pulse with ram_addr=0x7FFF; a subsequent port1 read of 0x7FFF returns 0x3C.
REQ-043 Contention: NPORTS=2, both ports hold req continuously -> grants alternate 0,1,0,1, with ack spacing WAIT+3 cycles.
REQ-044 Reset mid-write: rst_n low on the first ACCESS cycle with WAIT=3 -> no ram_we, no ack; outputs at reset values.
REQ-045 WAIT_CYCLES=0 read: ack at cycle 2 after req sampling; ram_re high for exactly 1 cycle.
REQ-046 Dropped request: port0 deasserts req during ACCESS -> ack[0] still pulses once, and busy returns to 0 the cycle after.
